// File: rtl/serial_byte_receiver.sv
// UART-style receiver for a pre-synchronized line: LSB-first frames with start/stop bits.
// Each good word is presented with a one-cycle data_valid strobe.
module serial_byte_receiver #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             framing_error,
    output logic             busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(WIDTH) + 1;
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    logic [CW-1:0]    tick;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] shift_reg;

    // START waits only half a bit, so every later full-bit count lands at mid-bit.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state         <= IDLE;
            tick          <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (!serial_in) begin
                        state <= START;
                        tick  <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick == HALF_LAST) begin
                        tick <= '0;
                        if (!serial_in) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (tick == BIT_LAST) begin
                        shift_reg <= {serial_in, shift_reg[WIDTH-1:1]};
                        tick      <= '0;
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    if (tick == BIT_LAST) begin
                        tick <= '0;
                        if (serial_in) begin
                            data_out   <= shift_reg;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= WAIT_HIGH;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                // A held-low (break) line must not be mistaken for a new start bit.
                WAIT_HIGH: begin
                    if (serial_in) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed bench for serial_byte_receiver: a fast-baud instance (4 clocks/bit) and a default instance.
// Strobes are logged by a monitor; expected values are hand-computed constants.
module tb_serial_byte_receiver;

    localparam int CPB4  = 4;
    localparam int CPB16 = 16;
    localparam int LAT16 = 1 + (CPB16 / 2 - 1) + 8 * CPB16 + CPB16 + 1;

    logic       clock;
    logic       reset_L;
    logic       serial4;
    logic       serial16;
    logic [7:0] data_out4;
    logic [7:0] data_out16;
    logic       valid4;
    logic       valid16;
    logic       fe4;
    logic       fe16;
    logic       busy4;
    logic       busy16;

    int tests    = 0;
    int failures = 0;
    int cyc      = 0;
    int fe_cnt4  = 0;
    int fe_cnt16 = 0;
    int overlap  = 0;
    logic prev_valid4  = 1'b0;
    logic prev_valid16 = 1'b0;

    logic [7:0] vq4[$];
    logic [7:0] vq16[$];
    int         cq4[$];
    int         cq16[$];

    serial_byte_receiver #(.WIDTH(8), .CLKS_PER_BIT(CPB4)) dut4 (
        .clock         (clock),
        .reset_L       (reset_L),
        .serial_in     (serial4),
        .data_out      (data_out4),
        .data_valid    (valid4),
        .framing_error (fe4),
        .busy          (busy4)
    );

    serial_byte_receiver dut16 (
        .clock         (clock),
        .reset_L       (reset_L),
        .serial_in     (serial16),
        .data_out      (data_out16),
        .data_valid    (valid16),
        .framing_error (fe16),
        .busy          (busy16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Log every strobe with the cycle it was seen in, and track pulse-shape violations.
    always @(posedge clock) begin
        #1;
        cyc = cyc + 1;
        if (valid4) begin
            vq4.push_back(data_out4);
            cq4.push_back(cyc);
        end
        if (valid16) begin
            vq16.push_back(data_out16);
            cq16.push_back(cyc);
        end
        if (fe4) fe_cnt4 = fe_cnt4 + 1;
        if (fe16) fe_cnt16 = fe_cnt16 + 1;
        if ((valid4 && fe4) || (valid16 && fe16)) overlap = overlap + 1;
        if ((valid4 && prev_valid4) || (valid16 && prev_valid16)) overlap = overlap + 1;
        prev_valid4  = valid4;
        prev_valid16 = valid16;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests = tests + 1;
        assert (observed === expected)
        else begin
            failures = failures + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic holdLine(input int sel, input logic b, input int n);
        if (sel == 4) serial4 = b;
        else serial16 = b;
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic stop_bit);
        holdLine(4, 1'b0, CPB4);
        for (int i = 0; i < 8; i++) holdLine(4, d[i], CPB4);
        holdLine(4, stop_bit, CPB4);
    endtask

    initial begin
        int b;
        int f;
        int c0;
        logic [7:0] d;

        serial4  = 1'b1;
        serial16 = 1'b1;
        reset_L  = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_data4", data_out4, 8'h00);
        checkOutput("reset_valid4", valid4, 1'b0);
        checkOutput("reset_fe4", fe4, 1'b0);
        checkOutput("reset_busy4", busy4, 1'b0);
        checkOutput("reset_data16", data_out16, 8'h00);
        checkOutput("reset_busy16", busy16, 1'b0);
        reset_L = 1'b1;
        holdLine(4, 1'b1, 4);

        $display("[TB] good frame 0xA5");
        b = vq4.size();
        f = fe_cnt4;
        applyStimulus(8'hA5, 1'b1);
        holdLine(4, 1'b1, 4);
        checkOutput("good_count", vq4.size() - b, 1);
        checkOutput("good_data", vq4[$], 8'hA5);
        checkOutput("good_fe", fe_cnt4 - f, 0);
        checkOutput("good_busy", busy4, 1'b0);
        checkOutput("good_hold", data_out4, 8'hA5);

        $display("[TB] glitch start");
        b = vq4.size();
        f = fe_cnt4;
        holdLine(4, 1'b0, 1);
        checkOutput("glitch_busy_start", busy4, 1'b1);
        holdLine(4, 1'b1, 12);
        checkOutput("glitch_count", vq4.size() - b, 0);
        checkOutput("glitch_fe", fe_cnt4 - f, 0);
        checkOutput("glitch_data", data_out4, 8'hA5);
        checkOutput("glitch_busy_end", busy4, 1'b0);

        $display("[TB] framing error 0x3C");
        b = vq4.size();
        f = fe_cnt4;
        d = 8'h3C;
        holdLine(4, 1'b0, CPB4);
        for (int i = 0; i < 8; i++) holdLine(4, d[i], CPB4);
        holdLine(4, 1'b0, 20);
        checkOutput("ferr_pulse", fe_cnt4 - f, 1);
        checkOutput("ferr_wait_busy", busy4, 1'b1);
        holdLine(4, 1'b1, 8);
        checkOutput("ferr_idle", busy4, 1'b0);
        checkOutput("ferr_no_valid", vq4.size() - b, 0);
        checkOutput("ferr_single", fe_cnt4 - f, 1);
        checkOutput("ferr_data", data_out4, 8'hA5);

        $display("[TB] back-to-back 0x00 0xFF 0x81");
        b = vq4.size();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h81, 1'b1);
        holdLine(4, 1'b1, 4);
        checkOutput("b2b_count", vq4.size() - b, 3);
        checkOutput("b2b_data0", vq4[b], 8'h00);
        checkOutput("b2b_data1", vq4[b+1], 8'hFF);
        checkOutput("b2b_data2", vq4[b+2], 8'h81);
        checkOutput("b2b_gap01", cq4[b+1] - cq4[b], 10 * CPB4);
        checkOutput("b2b_gap12", cq4[b+2] - cq4[b+1], 10 * CPB4);

        $display("[TB] reset mid-frame");
        b = vq4.size();
        f = fe_cnt4;
        holdLine(4, 1'b0, CPB4);
        holdLine(4, 1'b1, CPB4);
        holdLine(4, 1'b0, CPB4);
        holdLine(4, 1'b1, CPB4);
        holdLine(4, 1'b0, 2);
        reset_L = 1'b0;
        serial4 = 1'b1;
        @(negedge clock);
        reset_L = 1'b1;
        checkOutput("mid_reset_data", data_out4, 8'h00);
        checkOutput("mid_reset_busy", busy4, 1'b0);
        checkOutput("mid_reset_valid", valid4, 1'b0);
        holdLine(4, 1'b1, 8);
        applyStimulus(8'h99, 1'b1);
        holdLine(4, 1'b1, 4);
        checkOutput("mid_reset_count", vq4.size() - b, 1);
        checkOutput("mid_reset_new", vq4[$], 8'h99);
        checkOutput("mid_reset_fe", fe_cnt4 - f, 0);

        $display("[TB] default parameters 0x6E");
        b = vq16.size();
        f = fe_cnt16;
        d = 8'h6E;
        c0 = cyc + 1;
        holdLine(16, 1'b0, CPB16);
        for (int i = 0; i < 8; i++) holdLine(16, d[i], CPB16);
        holdLine(16, 1'b1, CPB16);
        holdLine(16, 1'b1, 16);
        checkOutput("dflt_count", vq16.size() - b, 1);
        checkOutput("dflt_data", vq16[$], 8'h6E);
        checkOutput("dflt_latency", cq16[$] - c0 + 1, LAT16);
        checkOutput("dflt_fe", fe_cnt16 - f, 0);
        checkOutput("dflt_busy", busy16, 1'b0);

        checkOutput("strobe_shape", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
